// File: rtl/branch_predictor_pkg.sv
// Shared definitions for the fetch-side branch predictor: counter states,
// branch-type codes and small helpers used by the top and the table.
package branch_predictor_pkg;

    localparam int BP_IDX_W = 6;
    localparam int BP_TAG_W = 8;

    typedef enum logic [1:0] {
        CTR_SNT = 2'b00,
        CTR_WNT = 2'b01,
        CTR_WT  = 2'b10,
        CTR_ST  = 2'b11
    } ctr_t;

    // Encodings of the EX-stage br_type bus; any other value is a non-branch.
    typedef enum logic [3:0] {
        BR_NONE = 4'd0,
        BR_JIRL = 4'd1,
        BR_B    = 4'd2,
        BR_BL   = 4'd3,
        BR_BEQ  = 4'd4,
        BR_BNE  = 4'd5,
        BR_BLT  = 4'd6,
        BR_BGE  = 4'd7,
        BR_BLTU = 4'd8,
        BR_BGEU = 4'd9
    } br_type_t;

    function automatic logic isBranch(input logic [3:0] brType);
        logic result;
        result = 1'b0;
        case (brType)
            BR_JIRL, BR_B, BR_BL, BR_BEQ, BR_BNE,
            BR_BLT, BR_BGE, BR_BLTU, BR_BGEU: result = 1'b1;
            default:                          result = 1'b0;
        endcase
        return result;
    endfunction

    function automatic ctr_t ctrNext(input ctr_t cur, input logic taken);
        ctr_t nxt;
        nxt = cur;
        if (taken) begin
            if (cur != CTR_ST) nxt = ctr_t'(cur + 2'd1);
        end else begin
            if (cur != CTR_SNT) nxt = ctr_t'(cur - 2'd1);
        end
        return nxt;
    endfunction

endpackage

// File: rtl/branch_predictor_table.sv
// Direct-mapped BHT/BTB storage: valid, partial tag, 2-bit counter and target per entry.
// Two asynchronous read ports (IF lookup, EX read-modify-write) and one synchronous write port.
module branch_predictor_table
    import branch_predictor_pkg::*;
#(
    parameter int IDX_W = BP_IDX_W,
    parameter int TAG_W = BP_TAG_W
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [IDX_W-1:0] i_ifIdx,
    output logic             o_ifValid,
    output logic [TAG_W-1:0] o_ifTag,
    output ctr_t             o_ifCtr,
    output logic [31:0]      o_ifTarget,
    input  logic [IDX_W-1:0] i_exIdx,
    output logic             o_exValid,
    output logic [TAG_W-1:0] o_exTag,
    output ctr_t             o_exCtr,
    output logic [31:0]      o_exTarget,
    input  logic             i_we,
    input  logic [IDX_W-1:0] i_wIdx,
    input  logic             i_wValid,
    input  logic [TAG_W-1:0] i_wTag,
    input  ctr_t             i_wCtr,
    input  logic [31:0]      i_wTarget
);

    localparam int ENTRIES = 1 << IDX_W;

    logic             r_valid  [ENTRIES];
    logic [TAG_W-1:0] r_tag    [ENTRIES];
    ctr_t             r_ctr    [ENTRIES];
    logic [31:0]      r_target [ENTRIES];

    assign o_ifValid  = r_valid[i_ifIdx];
    assign o_ifTag    = r_tag[i_ifIdx];
    assign o_ifCtr    = r_ctr[i_ifIdx];
    assign o_ifTarget = r_target[i_ifIdx];

    assign o_exValid  = r_valid[i_exIdx];
    assign o_exTag    = r_tag[i_exIdx];
    assign o_exCtr    = r_ctr[i_exIdx];
    assign o_exTarget = r_target[i_exIdx];

    // Whole-entry write keeps the four fields of an index consistent.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_valid[i]  <= 1'b0;
                r_tag[i]    <= '0;
                r_ctr[i]    <= CTR_WNT;
                r_target[i] <= '0;
            end
        end else if (i_we) begin
            r_valid[i_wIdx]  <= i_wValid;
            r_tag[i_wIdx]    <= i_wTag;
            r_ctr[i_wIdx]    <= i_wCtr;
            r_target[i_wIdx] <= i_wTarget;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Fetch-side branch predictor: combinational IF lookup, EX-stage training and mispredict redirect.
// Define BP_STATS_EN to add the stat_br_cnt / stat_miss_cnt counters.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int IDX_W = BP_IDX_W,
    parameter int TAG_W = BP_TAG_W
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] if_pc,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        ex_valid,
    input  logic [31:0] ex_pc,
    input  logic [3:0]  ex_br_type,
    input  logic        ex_taken,
    input  logic [31:0] ex_target,
    input  logic        ex_pred_taken,
    input  logic [31:0] ex_pred_target,
    output logic        redirect,
    output logic [31:0] redirect_pc
`ifdef BP_STATS_EN
    ,
    output logic [31:0] stat_br_cnt,
    output logic [31:0] stat_miss_cnt
`endif
);

    logic [IDX_W-1:0] w_ifIdx;
    logic [TAG_W-1:0] w_ifTag;
    logic             w_ifValidRd;
    logic [TAG_W-1:0] w_ifTagRd;
    ctr_t             w_ifCtrRd;
    logic [31:0]      w_ifTargetRd;
    logic             w_ifHit;

    logic [IDX_W-1:0] w_exIdx;
    logic [TAG_W-1:0] w_exTag;
    logic             w_exValidRd;
    logic [TAG_W-1:0] w_exTagRd;
    ctr_t             w_exCtrRd;
    logic [31:0]      w_exTargetRd;
    logic             w_exHit;
    logic             w_exIsBr;
    logic             w_exMiss;

    logic             w_we;
    logic             w_wValid;
    logic [TAG_W-1:0] w_wTag;
    ctr_t             w_wCtr;
    logic [31:0]      w_wTarget;

    assign w_ifIdx = if_pc[IDX_W+1:2];
    assign w_ifTag = if_pc[IDX_W+TAG_W+1:IDX_W+2];
    assign w_exIdx = ex_pc[IDX_W+1:2];
    assign w_exTag = ex_pc[IDX_W+TAG_W+1:IDX_W+2];

    branch_predictor_table #(
        .IDX_W(IDX_W),
        .TAG_W(TAG_W)
    ) u_table (
        .clk       (clk),
        .rstn      (rstn),
        .i_ifIdx   (w_ifIdx),
        .o_ifValid (w_ifValidRd),
        .o_ifTag   (w_ifTagRd),
        .o_ifCtr   (w_ifCtrRd),
        .o_ifTarget(w_ifTargetRd),
        .i_exIdx   (w_exIdx),
        .o_exValid (w_exValidRd),
        .o_exTag   (w_exTagRd),
        .o_exCtr   (w_exCtrRd),
        .o_exTarget(w_exTargetRd),
        .i_we      (w_we),
        .i_wIdx    (w_exIdx),
        .i_wValid  (w_wValid),
        .i_wTag    (w_wTag),
        .i_wCtr    (w_wCtr),
        .i_wTarget (w_wTarget)
    );

    assign w_ifHit     = w_ifValidRd && (w_ifTagRd == w_ifTag);
    assign pred_taken  = w_ifHit && w_ifCtrRd[1];
    assign pred_target = pred_taken ? w_ifTargetRd : (if_pc + 32'd4);

    assign w_exHit  = w_exValidRd && (w_exTagRd == w_exTag);
    assign w_exIsBr = isBranch(ex_br_type);

    always_comb begin
        w_exMiss = 1'b0;
        if (w_exIsBr) begin
            w_exMiss = (ex_taken != ex_pred_taken) ||
                       (ex_taken && (ex_target != ex_pred_target));
        end else begin
            w_exMiss = ex_pred_taken;
        end
    end

    assign redirect    = ex_valid && w_exMiss;
    assign redirect_pc = (w_exIsBr && ex_taken) ? ex_target : (ex_pc + 32'd4);

    // Training: hits adjust the counter, taken misses allocate weak-taken,
    // and a non-branch that hits an aliased entry knocks it out.
    always_comb begin
        w_we      = 1'b0;
        w_wValid  = w_exValidRd;
        w_wTag    = w_exTagRd;
        w_wCtr    = w_exCtrRd;
        w_wTarget = w_exTargetRd;
        if (ex_valid) begin
            if (w_exIsBr) begin
                if (w_exHit) begin
                    w_we   = 1'b1;
                    w_wCtr = ctrNext(w_exCtrRd, ex_taken);
                    if (ex_taken) w_wTarget = ex_target;
                end else if (ex_taken) begin
                    w_we      = 1'b1;
                    w_wValid  = 1'b1;
                    w_wTag    = w_exTag;
                    w_wCtr    = CTR_WT;
                    w_wTarget = ex_target;
                end
            end else if (w_exHit) begin
                w_we     = 1'b1;
                w_wValid = 1'b0;
            end
        end
    end

`ifdef BP_STATS_EN
    logic [31:0] r_brCnt;
    logic [31:0] r_missCnt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_brCnt   <= '0;
            r_missCnt <= '0;
        end else begin
            if (ex_valid && w_exIsBr) r_brCnt <= r_brCnt + 32'd1;
            if (redirect)             r_missCnt <= r_missCnt + 32'd1;
        end
    end

    assign stat_br_cnt   = r_brCnt;
    assign stat_miss_cnt = r_missCnt;
`endif

endmodule
